// File: rtl/inst_mem_loader_if.sv
// Purpose: bundles the program-load stream, the fetch port and the loader
//          status signals of inst_mem_loader into a single interface.
// Signals:
//   ld_start  - pulse: begin (re)load at address 0
//   ld_valid  - ld_data holds a word to store
//   ld_data   - program word
//   ld_last   - marks ld_data as the final word of the program
//   ld_ready  - loader accepts a word this cycle
//   pc_addr   - fetch address (core pc_out)
//   inst_word - instruction to core inst_in (combinational)
//   run       - program loaded; fetches are valid
//   ld_count  - words stored so far
//   ld_err    - overflow: DEPTH words stored with no ld_last
// Modports: master = host/core side, slave = loader side.
interface inst_mem_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              ld_start;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic [ADDR_W-1:0] pc_addr;
  logic [DATA_W-1:0] inst_word;
  logic              run;
  logic [ADDR_W:0]   ld_count;
  logic              ld_err;

  modport master (
    output ld_start, ld_valid, ld_data, ld_last, pc_addr,
    input  ld_ready, inst_word, run, ld_count, ld_err
  );

  modport slave (
    input  ld_start, ld_valid, ld_data, ld_last, pc_addr,
    output ld_ready, inst_word, run, ld_count, ld_err
  );
endinterface

// File: rtl/inst_mem_loader.sv
// Purpose: instruction store sitting in front of the core's IF stage. A host
//          streams a program in word by word over a valid/ready handshake;
//          once the final word is accepted the store serves instructions
//          combinationally, addressed by the core's program counter. Any
//          fetch outside the loaded region, or while no complete program is
//          present, returns NOP_WORD.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - inst_mem_loader_if.slave (load stream, fetch port, status)
module inst_mem_loader #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 1 << ADDR_W,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input logic             clk,
  input logic             rst,
  inst_mem_loader_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);

  logic [1:0]        state;
  logic [ADDR_W:0]   count;
  logic              accept;
  logic [DATA_W-1:0] mem [DEPTH];

  // A word is only taken while loading, and a ld_start in the same cycle
  // wins: the restart discards that word rather than storing it.
  assign accept = (state == LOAD) && bus.ld_valid && !bus.ld_start;

  // Control state and write pointer. The overflow check uses the address
  // being written, so the DEPTH-th word without ld_last lands in ERR with
  // the count already at DEPTH. A last word at the final address still
  // counts as a clean finish.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else if (bus.ld_start) begin
      state <= LOAD;
      count <= '0;
    end else if (accept) begin
      count <= count + 1'b1;
      if (bus.ld_last) begin
        state <= RUN;
      end else if (count == LAST_ADDR) begin
        state <= ERR;
      end
    end
  end

  // Storage is deliberately left uncleared by reset; the fetch guard below
  // keeps stale contents from ever reaching the core.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      mem[count[ADDR_W-1:0]] <= bus.ld_data;
    end
  end

  assign bus.ld_ready = (state == LOAD);
  assign bus.run      = (state == RUN);
  assign bus.ld_err   = (state == ERR);
  assign bus.ld_count = count;

  // Zero-latency fetch so the core's IF register captures it on the same
  // edge. The address is widened by one bit so it compares cleanly against
  // a count that can reach DEPTH.
  assign bus.inst_word = (bus.run && ({1'b0, bus.pc_addr} < count))
                         ? mem[bus.pc_addr] : NOP_WORD;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Purpose: directed testbench for inst_mem_loader. A full-size instance
//          (ADDR_W=8) covers loading, fetching, reload and reset; a small
//          instance (ADDR_W=2) covers the overflow path.
module tb_inst_mem_loader;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  inst_mem_loader_if #(.ADDR_W(8), .DATA_W(16)) m_if ();
  inst_mem_loader_if #(.ADDR_W(2), .DATA_W(16)) s_if ();

  inst_mem_loader #(.ADDR_W(8), .DATA_W(16)) u_main (
    .clk (clk),
    .rst (rst),
    .bus (m_if)
  );

  inst_mem_loader #(.ADDR_W(2), .DATA_W(16)) u_small (
    .clk (clk),
    .rst (rst),
    .bus (s_if)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_if.ld_start = 1'b0; m_if.ld_valid = 1'b0; m_if.ld_data = '0;
    m_if.ld_last  = 1'b0; m_if.pc_addr  = '0;
    s_if.ld_start = 1'b0; s_if.ld_valid = 1'b0; s_if.ld_data = '0;
    s_if.ld_last  = 1'b0; s_if.pc_addr  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (m_if.ld_ready !== 1'b0 || m_if.run !== 1'b0 || m_if.ld_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got ready=%b run=%b err=%b expected 0 0 0",
               m_if.ld_ready, m_if.run, m_if.ld_err);
    end
    checks++;
    if (m_if.ld_count !== 9'd0) begin
      errors++;
      $display("[TB] FAIL reset_count: got %0d expected 0", m_if.ld_count);
    end
    checks++;
    if (m_if.inst_word !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_fetch: got %h expected 0000", m_if.inst_word);
    end
    checks++;
    if (s_if.ld_ready !== 1'b0 || s_if.ld_err !== 1'b0 || s_if.ld_count !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_small: got ready=%b err=%b count=%0d expected 0 0 0",
               s_if.ld_ready, s_if.ld_err, s_if.ld_count);
    end
  endtask

  task automatic test_basic_load();
    logic [15:0] words [3];
    logic [15:0] exp;
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
    m_if.ld_start = 1'b1;
    tick();
    m_if.ld_start = 1'b0;
    checks++;
    if (m_if.ld_ready !== 1'b1 || m_if.ld_count !== 9'd0) begin
      errors++;
      $display("[TB] FAIL basic_load_enter: got ready=%b count=%0d expected 1 0",
               m_if.ld_ready, m_if.ld_count);
    end
    for (int i = 0; i < 3; i++) begin
      m_if.ld_valid = 1'b1;
      m_if.ld_data  = words[i];
      m_if.ld_last  = (i == 2);
      tick();
    end
    m_if.ld_valid = 1'b0;
    m_if.ld_last  = 1'b0;
    checks++;
    if (m_if.run !== 1'b1 || m_if.ld_count !== 9'd3 || m_if.ld_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_load_done: got run=%b count=%0d ready=%b expected 1 3 0",
               m_if.run, m_if.ld_count, m_if.ld_ready);
    end
    for (int p = 0; p < 4; p++) begin
      m_if.pc_addr = 8'(p);
      exp = (p < 3) ? words[p] : 16'h0000;
      #1;
      checks++;
      if (m_if.inst_word !== exp) begin
        errors++;
        $display("[TB] FAIL basic_fetch pc=%0d: got %h expected %h", p, m_if.inst_word, exp);
      end
    end
  endtask

  task automatic test_gapped_load();
    logic [15:0] words [3];
    int          idx;
    words[0] = 16'hA1A1; words[1] = 16'hB2B2; words[2] = 16'hC3C3;
    m_if.ld_start = 1'b1;
    tick();
    m_if.ld_start = 1'b0;
    idx = 0;
    // Valid on even cycles only; ready must stay high the whole load.
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (m_if.ld_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL gapped_ready cycle=%0d: got %b expected 1", c, m_if.ld_ready);
      end
      if (c % 2 == 0) begin
        m_if.ld_valid = 1'b1;
        m_if.ld_data  = words[idx];
        m_if.ld_last  = (idx == 2);
        idx++;
      end else begin
        m_if.ld_valid = 1'b0;
        m_if.ld_data  = 16'hFFFF;
        m_if.ld_last  = 1'b1;
      end
      tick();
      if (idx == 3) break;
    end
    m_if.ld_valid = 1'b0;
    m_if.ld_last  = 1'b0;
    checks++;
    if (m_if.run !== 1'b1 || m_if.ld_count !== 9'd3) begin
      errors++;
      $display("[TB] FAIL gapped_done: got run=%b count=%0d expected 1 3", m_if.run, m_if.ld_count);
    end
    for (int p = 0; p < 3; p++) begin
      m_if.pc_addr = 8'(p);
      #1;
      checks++;
      if (m_if.inst_word !== words[p]) begin
        errors++;
        $display("[TB] FAIL gapped_fetch pc=%0d: got %h expected %h", p, m_if.inst_word, words[p]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] words [4];
    words[0] = 16'h0101; words[1] = 16'h0202; words[2] = 16'h0303; words[3] = 16'h0404;
    s_if.ld_start = 1'b1;
    tick();
    s_if.ld_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_if.ld_valid = 1'b1;
      s_if.ld_data  = words[i];
      s_if.ld_last  = 1'b0;
      tick();
    end
    checks++;
    if (s_if.ld_err !== 1'b1 || s_if.ld_count !== 3'd4 || s_if.ld_ready !== 1'b0 || s_if.run !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overflow_err: got err=%b count=%0d ready=%b run=%b expected 1 4 0 0",
               s_if.ld_err, s_if.ld_count, s_if.ld_ready, s_if.run);
    end
    // Fifth word, even flagged last, must be ignored in ERR.
    s_if.ld_data = 16'h0505;
    s_if.ld_last = 1'b1;
    tick();
    checks++;
    if (s_if.ld_err !== 1'b1 || s_if.ld_count !== 3'd4) begin
      errors++;
      $display("[TB] FAIL overflow_extra: got err=%b count=%0d expected 1 4", s_if.ld_err, s_if.ld_count);
    end
    s_if.ld_valid = 1'b0;
    s_if.ld_last  = 1'b0;
    s_if.ld_start = 1'b1;
    tick();
    s_if.ld_start = 1'b0;
    checks++;
    if (s_if.ld_err !== 1'b0 || s_if.ld_count !== 3'd0 || s_if.ld_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_clear: got err=%b count=%0d ready=%b expected 0 0 1",
               s_if.ld_err, s_if.ld_count, s_if.ld_ready);
    end
  endtask

  task automatic test_reload_in_run();
    m_if.pc_addr  = 8'd0;
    m_if.ld_start = 1'b1;
    m_if.ld_valid = 1'b1;
    m_if.ld_data  = 16'h9999;
    m_if.ld_last  = 1'b1;
    tick();
    m_if.ld_start = 1'b0;
    m_if.ld_valid = 1'b0;
    m_if.ld_last  = 1'b0;
    checks++;
    if (m_if.ld_count !== 9'd0 || m_if.run !== 1'b0 || m_if.ld_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reload_drop: got count=%0d run=%b ready=%b expected 0 0 1",
               m_if.ld_count, m_if.run, m_if.ld_ready);
    end
    checks++;
    if (m_if.inst_word !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reload_nop: got %h expected 0000", m_if.inst_word);
    end
    m_if.ld_valid = 1'b1;
    m_if.ld_data  = 16'hABCD;
    m_if.ld_last  = 1'b1;
    tick();
    m_if.ld_valid = 1'b0;
    m_if.ld_last  = 1'b0;
    checks++;
    if (m_if.run !== 1'b1 || m_if.ld_count !== 9'd1 || m_if.inst_word !== 16'hABCD) begin
      errors++;
      $display("[TB] FAIL reload_pc0: got run=%b count=%0d word=%h expected 1 1 abcd",
               m_if.run, m_if.ld_count, m_if.inst_word);
    end
    m_if.pc_addr = 8'd1;
    #1;
    checks++;
    if (m_if.inst_word !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reload_pc1: got %h expected 0000", m_if.inst_word);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] pcs [4];
    pcs[0] = 8'd0; pcs[1] = 8'd1; pcs[2] = 8'd2; pcs[3] = 8'd255;
    m_if.ld_start = 1'b1;
    tick();
    m_if.ld_start = 1'b0;
    m_if.ld_valid = 1'b1;
    m_if.ld_data  = 16'h5151;
    tick();
    m_if.ld_data  = 16'h5252;
    tick();
    m_if.ld_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (m_if.ld_count !== 9'd0 || m_if.ld_ready !== 1'b0 || m_if.run !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_state: got count=%0d ready=%b run=%b expected 0 0 0",
               m_if.ld_count, m_if.ld_ready, m_if.run);
    end
    for (int i = 0; i < 4; i++) begin
      m_if.pc_addr = pcs[i];
      #1;
      checks++;
      if (m_if.inst_word !== 16'h0000) begin
        errors++;
        $display("[TB] FAIL midrst_fetch pc=%0d: got %h expected 0000", pcs[i], m_if.inst_word);
      end
    end
    m_if.ld_valid = 1'b1;
    m_if.ld_data  = 16'h5353;
    tick();
    m_if.ld_valid = 1'b0;
    checks++;
    if (m_if.ld_count !== 9'd0) begin
      errors++;
      $display("[TB] FAIL midrst_ignore: got count=%0d expected 0", m_if.ld_count);
    end
  endtask

  task automatic test_idle_write_ignored();
    m_if.ld_valid = 1'b1;
    m_if.ld_data  = 16'hDEAD;
    tick();
    m_if.ld_valid = 1'b0;
    checks++;
    if (m_if.ld_count !== 9'd0 || m_if.ld_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_ignore: got count=%0d ready=%b expected 0 0", m_if.ld_count, m_if.ld_ready);
    end
    m_if.ld_start = 1'b1;
    tick();
    m_if.ld_start = 1'b0;
    m_if.ld_valid = 1'b1;
    m_if.ld_data  = 16'h7777;
    m_if.ld_last  = 1'b1;
    tick();
    m_if.ld_valid = 1'b0;
    m_if.ld_last  = 1'b0;
    m_if.pc_addr  = 8'd0;
    #1;
    checks++;
    if (m_if.inst_word !== 16'h7777 || m_if.ld_count !== 9'd1) begin
      errors++;
      $display("[TB] FAIL idle_then_load: got word=%h count=%0d expected 7777 1",
               m_if.inst_word, m_if.ld_count);
    end
    m_if.pc_addr = 8'd255;
    #1;
    checks++;
    if (m_if.inst_word !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL idle_pc_top: got %h expected 0000", m_if.inst_word);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    clear_inputs();
    $display("[TB] starting inst_mem_loader bench");
    test_reset();
    test_basic_load();
    test_gapped_load();
    test_overflow();
    test_reload_in_run();
    test_reset_mid_load();
    test_idle_write_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
